// File: rtl/alu_issue_ctrl_if.sv
// Handshake and datapath bundle between the issue/retire controller and its
// neighbours: ID/EX upstream, the combinational ALU, and EX/MEM downstream.
interface alu_issue_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) ();
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        alu_op;
  logic [5:0]        funct;
  logic              is_branch;
  logic              branch_ne;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [3:0]        alu_ctrl;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic              out_zero;
  logic              out_branch_taken;
  logic              out_illegal;
  logic [CNT_W-1:0]  retired_cnt;

  // The controller side.
  modport slave (
    input  flush, in_valid, alu_op, funct, is_branch, branch_ne, op_a, op_b,
    input  alu_result, alu_zero, out_ready,
    output in_ready, alu_ctrl, alu_a, alu_b,
    output out_valid, out_result, out_zero, out_branch_taken, out_illegal, retired_cnt
  );

  // The surrounding pipeline, ALU and downstream consumer.
  modport master (
    output flush, in_valid, alu_op, funct, is_branch, branch_ne, op_a, op_b,
    output alu_result, alu_zero, out_ready,
    input  in_ready, alu_ctrl, alu_a, alu_b,
    input  out_valid, out_result, out_zero, out_branch_taken, out_illegal, retired_cnt
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// MIPS32 ALU issue/retire controller: decodes ALUOp/funct, registers operands
// for the ALU (S1), captures result/Zero and resolves beq/bne (S2).
module alu_issue_ctrl #(
  parameter int         DATA_W       = 32,
  parameter logic [3:0] ILLEGAL_CODE = 4'b1111,
  parameter int         CNT_W        = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  alu_issue_ctrl_if.slave bus
);

  logic              v1_reg, v2_reg;
  logic [3:0]        ctrl_reg;
  logic [DATA_W-1:0] a_reg, b_reg;
  logic              br_reg, ne_reg, ill1_reg;
  logic [DATA_W-1:0] res_reg;
  logic              zero_reg, taken_reg, ill2_reg;
  logic [CNT_W-1:0]  cnt_reg;

  logic [3:0] ctrl_next;
  logic       ill_next;
  logic       adv2, accept, s1_to_s2, retire;

  always_comb begin
    ctrl_next = ILLEGAL_CODE;
    ill_next  = 1'b1;
    case (bus.alu_op)
      2'b00: begin ctrl_next = 4'b0010; ill_next = 1'b0; end
      2'b01: begin ctrl_next = 4'b0110; ill_next = 1'b0; end
      2'b10: begin
        case (bus.funct)
          6'b100000: begin ctrl_next = 4'b0010; ill_next = 1'b0; end
          6'b100010: begin ctrl_next = 4'b0110; ill_next = 1'b0; end
          6'b100100: begin ctrl_next = 4'b0000; ill_next = 1'b0; end
          6'b100101: begin ctrl_next = 4'b0001; ill_next = 1'b0; end
          6'b100111: begin ctrl_next = 4'b1100; ill_next = 1'b0; end
          6'b101010: begin ctrl_next = 4'b0111; ill_next = 1'b0; end
          default:   begin ctrl_next = ILLEGAL_CODE; ill_next = 1'b1; end
        endcase
      end
      default: begin ctrl_next = ILLEGAL_CODE; ill_next = 1'b1; end
    endcase
  end

  // S2 frees up either because it is empty or its content leaves this cycle.
  assign adv2     = !v2_reg || bus.out_ready;
  assign accept   = bus.in_valid && bus.in_ready;
  assign s1_to_s2 = v1_reg && adv2;
  assign retire   = v2_reg && bus.out_ready && !bus.flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_reg   <= 1'b0;
      ctrl_reg <= ILLEGAL_CODE;
      a_reg    <= '0;
      b_reg    <= '0;
      br_reg   <= 1'b0;
      ne_reg   <= 1'b0;
      ill1_reg <= 1'b0;
    end else begin
      if (bus.flush)
        v1_reg <= 1'b0;
      else if (accept)
        v1_reg <= 1'b1;
      else if (s1_to_s2)
        v1_reg <= 1'b0;
      // accept is already gated by flush through in_ready
      if (accept) begin
        ctrl_reg <= ctrl_next;
        a_reg    <= bus.op_a;
        b_reg    <= bus.op_b;
        br_reg   <= bus.is_branch;
        ne_reg   <= bus.branch_ne;
        ill1_reg <= ill_next;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v2_reg    <= 1'b0;
      res_reg   <= '0;
      zero_reg  <= 1'b0;
      taken_reg <= 1'b0;
      ill2_reg  <= 1'b0;
    end else begin
      if (bus.flush)
        v2_reg <= 1'b0;
      else if (s1_to_s2)
        v2_reg <= 1'b1;
      else if (bus.out_ready)
        v2_reg <= 1'b0;
      if (s1_to_s2 && !bus.flush) begin
        res_reg   <= ill1_reg ? '0 : bus.alu_result;
        zero_reg  <= bus.alu_zero;
        ill2_reg  <= ill1_reg;
        taken_reg <= br_reg && !ill1_reg && (ne_reg ? !bus.alu_zero : bus.alu_zero);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cnt_reg <= '0;
    else if (retire && (cnt_reg != '1))
      cnt_reg <= cnt_reg + 1'b1;
  end

  assign bus.in_ready         = (!v1_reg || adv2) && !bus.flush;
  assign bus.alu_ctrl         = ctrl_reg;
  assign bus.alu_a            = a_reg;
  assign bus.alu_b            = b_reg;
  assign bus.out_valid        = v2_reg;
  assign bus.out_result       = res_reg;
  assign bus.out_zero         = zero_reg;
  assign bus.out_branch_taken = taken_reg;
  assign bus.out_illegal      = ill2_reg;
  assign bus.retired_cnt      = cnt_reg;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural MIPS ALU attached.
module tb_alu_issue_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [15:0] cnt_exp = '0;

  alu_issue_ctrl_if #(.DATA_W(32), .CNT_W(16)) bus ();

  alu_issue_ctrl #(.DATA_W(32), .ILLEGAL_CODE(4'b1111), .CNT_W(16)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Combinational ALU in front of the controller.
  always_comb begin
    case (bus.alu_ctrl)
      4'b0000: bus.alu_result = bus.alu_a & bus.alu_b;
      4'b0001: bus.alu_result = bus.alu_a | bus.alu_b;
      4'b0010: bus.alu_result = bus.alu_a + bus.alu_b;
      4'b0110: bus.alu_result = bus.alu_a - bus.alu_b;
      4'b0111: bus.alu_result = ($signed(bus.alu_a) < $signed(bus.alu_b)) ? 32'd1 : 32'd0;
      4'b1100: bus.alu_result = ~(bus.alu_a | bus.alu_b);
      default: bus.alu_result = 32'd0;
    endcase
    bus.alu_zero = (bus.alu_result == 32'd0);
  end

  task automatic set_op(input logic [1:0] op, input logic [5:0] fn,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic br, input logic ne);
    bus.in_valid  = 1'b1;
    bus.alu_op    = op;
    bus.funct     = fn;
    bus.op_a      = a;
    bus.op_b      = b;
    bus.is_branch = br;
    bus.branch_ne = ne;
  endtask

  task automatic test_reset;
    bus.flush = 0; bus.in_valid = 0; bus.out_ready = 0;
    bus.alu_op = 0; bus.funct = 0; bus.op_a = 0; bus.op_b = 0;
    bus.is_branch = 0; bus.branch_ne = 0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.alu_ctrl !== 4'b1111) begin errors++; $display("FAIL reset_alu_ctrl got %b exp 1111", bus.alu_ctrl); end
    checks++; if (bus.alu_a !== 32'd0 || bus.alu_b !== 32'd0) begin errors++; $display("FAIL reset_operands got %h/%h exp 0/0", bus.alu_a, bus.alu_b); end
    checks++; if (bus.out_result !== 32'd0 || bus.out_illegal !== 1'b0 || bus.out_branch_taken !== 1'b0) begin errors++; $display("FAIL reset_outputs got %h/%b/%b exp 0/0/0", bus.out_result, bus.out_illegal, bus.out_branch_taken); end
    checks++; if (bus.retired_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", bus.retired_cnt); end
    reset_n = 1'b1;
    $display("reset released");
  endtask

  task automatic test_add;
    @(negedge clk);
    set_op(2'b10, 6'b100000, 32'd5, 32'd7, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL add_in_ready got %b exp 1", bus.in_ready); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++; if (bus.alu_ctrl !== 4'b0010 || bus.alu_a !== 32'd5 || bus.alu_b !== 32'd7) begin errors++; $display("FAIL add_s1 got %b %0d %0d exp 0010 5 7", bus.alu_ctrl, bus.alu_a, bus.alu_b); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL add_latency got out_valid %b exp 0", bus.out_valid); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd12 || bus.out_zero !== 1'b0) begin errors++; $display("FAIL add_result got v=%b r=%0d z=%b exp 1 12 0", bus.out_valid, bus.out_result, bus.out_zero); end
    $display("add 5+7 -> %0d", bus.out_result);
    @(negedge clk);
    cnt_exp++;
    checks++; if (bus.retired_cnt !== cnt_exp || bus.out_valid !== 1'b0) begin errors++; $display("FAIL add_retire got cnt=%0d v=%b exp %0d 0", bus.retired_cnt, bus.out_valid, cnt_exp); end
  endtask

  task automatic test_branch;
    @(negedge clk); set_op(2'b01, 6'b0, 32'h1234, 32'h1234, 1'b1, 1'b0);
    @(negedge clk); set_op(2'b01, 6'b0, 32'h1234, 32'h1234, 1'b1, 1'b1);
    @(negedge clk); set_op(2'b01, 6'b0, 32'd1, 32'd2, 1'b1, 1'b1);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_zero !== 1'b1 || bus.out_branch_taken !== 1'b1) begin errors++; $display("FAIL beq_eq got v=%b z=%b t=%b exp 1 1 1", bus.out_valid, bus.out_zero, bus.out_branch_taken); end
    $display("beq 1234,1234 taken=%b", bus.out_branch_taken);
    @(negedge clk); bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_zero !== 1'b1 || bus.out_branch_taken !== 1'b0) begin errors++; $display("FAIL bne_eq got v=%b z=%b t=%b exp 1 1 0", bus.out_valid, bus.out_zero, bus.out_branch_taken); end
    $display("bne 1234,1234 taken=%b", bus.out_branch_taken);
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_zero !== 1'b0 || bus.out_branch_taken !== 1'b1) begin errors++; $display("FAIL bne_ne got v=%b z=%b t=%b exp 1 0 1", bus.out_valid, bus.out_zero, bus.out_branch_taken); end
    $display("bne 1,2 taken=%b", bus.out_branch_taken);
    @(negedge clk);
    cnt_exp += 3;
    checks++; if (bus.retired_cnt !== cnt_exp) begin errors++; $display("FAIL branch_cnt got %0d exp %0d", bus.retired_cnt, cnt_exp); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk); set_op(2'b10, 6'b101010, 32'd3, 32'd9, 1'b0, 1'b0);
    @(negedge clk); set_op(2'b10, 6'b100111, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk); bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd1) begin errors++; $display("FAIL slt got v=%b r=%h exp 1 00000001", bus.out_valid, bus.out_result); end
    $display("slt 3<9 -> %h", bus.out_result);
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL nor got v=%b r=%h exp 1 ffffffff", bus.out_valid, bus.out_result); end
    $display("nor 0,0 -> %h", bus.out_result);
    @(negedge clk);
    cnt_exp += 2;
    checks++; if (bus.retired_cnt !== cnt_exp || bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_cnt got %0d v=%b exp %0d 0", bus.retired_cnt, bus.out_valid, cnt_exp); end
  endtask

  task automatic test_stall;
    logic [31:0] a_tab [3] = '{32'd10, 32'd20, 32'd30};
    logic [31:0] b_tab [3] = '{32'd1, 32'd2, 32'd3};
    logic [31:0] r_tab [3] = '{32'd11, 32'd22, 32'd33};
    int idx = 0;
    int got = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      @(negedge clk);
      bus.out_ready = (cyc >= 5);
      if (idx < 3) set_op(2'b10, 6'b100000, a_tab[idx], b_tab[idx], 1'b0, 1'b0);
      else bus.in_valid = 1'b0;
      #1;
      if (cyc >= 2 && cyc <= 4) begin
        checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_result !== 32'd11) begin errors++; $display("FAIL stall_hold cyc %0d got rdy=%b v=%b r=%0d exp 0 1 11", cyc, bus.in_ready, bus.out_valid, bus.out_result); end
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (got >= 3) begin errors++; $display("FAIL stall_dup got extra result %0d", bus.out_result); end
        else if (bus.out_result !== r_tab[got]) begin errors++; $display("FAIL stall_order got %0d exp %0d", bus.out_result, r_tab[got]); end
        $display("stall retire %0d", bus.out_result);
        got++;
      end
      if (bus.in_valid && bus.in_ready) idx++;
    end
    checks++; if (idx != 3 || got != 3) begin errors++; $display("FAIL stall_count got acc=%0d ret=%0d exp 3 3", idx, got); end
    cnt_exp += 3;
    checks++; if (bus.retired_cnt !== cnt_exp) begin errors++; $display("FAIL stall_cnt got %0d exp %0d", bus.retired_cnt, cnt_exp); end
  endtask

  task automatic test_illegal;
    @(negedge clk); bus.out_ready = 1'b1; set_op(2'b10, 6'b000000, 32'd3, 32'd4, 1'b0, 1'b0);
    @(negedge clk); set_op(2'b11, 6'b0, 32'd5, 32'd5, 1'b1, 1'b0);
    checks++; if (bus.alu_ctrl !== 4'b1111) begin errors++; $display("FAIL illegal_ctrl got %b exp 1111", bus.alu_ctrl); end
    @(negedge clk); bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_illegal !== 1'b1 || bus.out_result !== 32'd0) begin errors++; $display("FAIL illegal_funct got v=%b i=%b r=%0d exp 1 1 0", bus.out_valid, bus.out_illegal, bus.out_result); end
    $display("illegal funct 000000 illegal=%b", bus.out_illegal);
    @(negedge clk);
    checks++; if (bus.out_illegal !== 1'b1 || bus.out_branch_taken !== 1'b0 || bus.out_result !== 32'd0) begin errors++; $display("FAIL illegal_op11 got i=%b t=%b r=%0d exp 1 0 0", bus.out_illegal, bus.out_branch_taken, bus.out_result); end
    $display("illegal aluop 11 illegal=%b", bus.out_illegal);
    @(negedge clk);
    cnt_exp += 2;
    checks++; if (bus.retired_cnt !== cnt_exp) begin errors++; $display("FAIL illegal_cnt got %0d exp %0d", bus.retired_cnt, cnt_exp); end
  endtask

  task automatic test_flush;
    @(negedge clk); bus.out_ready = 1'b0; set_op(2'b00, 6'b0, 32'd1, 32'd1, 1'b0, 1'b0);
    @(negedge clk); set_op(2'b00, 6'b0, 32'd2, 32'd2, 1'b0, 1'b0);
    @(negedge clk); set_op(2'b00, 6'b0, 32'd40, 32'd50, 1'b0, 1'b0);
    bus.flush = 1'b1; bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL flush_cycle got rdy=%b v=%b exp 0 1", bus.in_ready, bus.out_valid); end
    @(negedge clk); bus.flush = 1'b0; bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.retired_cnt !== cnt_exp) begin errors++; $display("FAIL flush_empty got v=%b cnt=%0d exp 0 %0d", bus.out_valid, bus.retired_cnt, cnt_exp); end
    checks++; if (bus.alu_a === 32'd40) begin errors++; $display("FAIL flush_no_accept got alu_a %0d exp not 40", bus.alu_a); end
    @(negedge clk); set_op(2'b00, 6'b0, 32'd6, 32'd7, 1'b0, 1'b0);
    checks++; if (bus.out_valid !== 1'b0 || bus.retired_cnt !== cnt_exp) begin errors++; $display("FAIL flush_s1_empty got v=%b cnt=%0d exp 0 %0d", bus.out_valid, bus.retired_cnt, cnt_exp); end
    $display("flush done cnt=%0d", bus.retired_cnt);
    @(negedge clk); bus.in_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd13) begin errors++; $display("FAIL flush_recover got v=%b r=%0d exp 1 13", bus.out_valid, bus.out_result); end
    @(negedge clk);
    cnt_exp++;
    checks++; if (bus.retired_cnt !== cnt_exp) begin errors++; $display("FAIL flush_recover_cnt got %0d exp %0d", bus.retired_cnt, cnt_exp); end
  endtask

  task automatic test_saturate;
    int budget = 0;
    @(negedge clk); bus.out_ready = 1'b1; set_op(2'b00, 6'b0, 32'd1, 32'd1, 1'b0, 1'b0);
    while (bus.retired_cnt !== 16'hFFFF && budget < 70000) begin
      @(negedge clk);
      budget++;
    end
    checks++; if (bus.retired_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_reach got %h exp ffff within budget", bus.retired_cnt); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL sat_pending got v=%b exp 1", bus.out_valid); end
    repeat (3) @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.retired_cnt !== 16'hFFFF || bus.out_valid !== 1'b0) begin errors++; $display("FAIL sat_hold got %h v=%b exp ffff 0", bus.retired_cnt, bus.out_valid); end
    $display("saturated cnt=%h", bus.retired_cnt);
  endtask

  task automatic test_async_reset;
    @(negedge clk); set_op(2'b00, 6'b0, 32'd8, 32'd8, 1'b0, 1'b0);
    @(negedge clk); bus.in_valid = 1'b0;
    checks++; if (bus.alu_ctrl !== 4'b0010 || bus.alu_a !== 32'd8) begin errors++; $display("FAIL areset_pre got %b %0d exp 0010 8", bus.alu_ctrl, bus.alu_a); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (bus.alu_ctrl !== 4'b1111 || bus.alu_a !== 32'd0 || bus.retired_cnt !== 16'd0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL areset_now got %b %0d %h %b exp 1111 0 0000 0", bus.alu_ctrl, bus.alu_a, bus.retired_cnt, bus.out_valid); end
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL areset_discard got v=%b exp 0", bus.out_valid); end
    $display("async reset discarded in-flight op");
  endtask

  initial begin
    test_reset();
    test_add();
    test_branch();
    test_back_to_back();
    test_stall();
    test_illegal();
    test_flush();
    test_saturate();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
